activation_scheduler: RTL and testbench
=======================================

// Module: activation_scheduler
// PURPOSE
//   Sequences one activation job: streams cfg_rows rows from the accumulator buffer through the
//   registered Activations unit (en/sel controlled here) and writes the results to the unified buffer.
//   Sits between the layer controller (start/done) and the accumulator -> Activations -> UB datapath.
//   Owns read/write addressing, function select and valid/ready backpressure from the UB write port.
// PARAMETERS
//   ADDR_W   10  width of accumulator-buffer and UB addresses
//   ROW_W    10  width of row-count field; a job is 0..2^ROW_W-1 rows
// PORTS
//   clk           in   1       single clock, rising edge
//   rst           in   1       asynchronous, active-high reset
//   start         in   1       job request; sampled only in IDLE
//   cfg_sel       in   2       activation function for the job (passed to Activations sel)
//   cfg_rows      in   ROW_W   number of rows in the job
//   cfg_src_base  in   ADDR_W  first accumulator-buffer row address
//   cfg_dst_base  in   ADDR_W  first UB row address
//   busy          out  1       high in RUN and DRAIN
//   done          out  1       one-cycle pulse when the job completes
//   acc_rd_en     out  1       accumulator-buffer read strobe; rdata valid next cycle, held while rd_en=0
//   acc_rd_addr   out  ADDR_W  read address
//   act_en        out  1       Activations clock enable (its output register holds when low)
//   act_sel       out  2       Activations function select
//   ub_wr_en      out  1       UB write valid
//   ub_wr_addr    out  ADDR_W  UB write address
//   ub_wr_ready   in   1       UB accepts the write this cycle when ub_wr_en & ub_wr_ready
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, acc_rd_en, act_en, ub_wr_en = 0; addresses, act_sel, counters = 0.
//   Config (sel, rows, src, dst) latched on the accepted start; start while not IDLE is ignored.
//   act_sel = latched sel for the whole job; stable from the first read until done.
//   FSM: IDLE -start&rows!=0-> RUN; IDLE -start&rows==0-> DONE; RUN -last read issued-> DRAIN;
//        DRAIN -last write accepted-> DONE; DONE -> IDLE unconditionally (done=1 only in DONE).
//   Pipeline (3 stages, valid bits v1/v2 in addition to the read issue):
//     issue: acc_rd_en=1, acc_rd_addr=src+rd_cnt when RUN & !stall; rd_cnt++.
//     v1 (rdata present): act_en=1 when v1 & !stall; v2 <= v1.
//     v2 (Activations out valid): ub_wr_en=v2, ub_wr_addr=dst+wr_cnt; wr_cnt++ on accept.
//   stall = v2 & !ub_wr_ready; on stall no read issue, act_en=0, v1/v2 and addresses frozen.
//   ub_wr_en stays asserted with a stable address until accepted (no drop, no duplicate).
//   Latency with ub_wr_ready=1: first ub_wr_en 3 cycles after start accepted; one row/cycle after that;
//   done 1 cycle after the last write accepted.
//   Address arithmetic is modulo 2^ADDR_W (src/dst + count wraps silently).
//   rows==0: no reads, no act_en, no writes; done pulses the cycle after start.
//   start in the DONE cycle is ignored; a new job is accepted from IDLE (the next cycle).
//   rst mid-job: immediate return to reset values; no done; in-flight rows are discarded.
// STRUCTURE
//   act_sched_pkg: state enum {IDLE,RUN,DRAIN,DONE}, act_sel_t (2-bit), ADDR_W/ROW_W defaults.
//   One sub-module act_sched_pipe: v1/v2 valid shift with stall, write counter and accept logic.
//   Top: FSM, config registers, read counter/address.
// TESTING
//   rows=4, src=0x010, dst=0x200, sel=2'b01, ready=1 -> reads 0x010..0x013 on cycles 1-4,
//     writes 0x200..0x203 on cycles 3-6, done at cycle 7, act_sel=01 throughout.
//   Same job, ub_wr_ready=0 for 3 cycles at the first write -> ub_wr_en held with addr 0x200,
//     act_en=0 and no reads during the stall, all 4 writes issued once, in order.
//   rows=0 -> done 1 cycle after start; acc_rd_en, act_en, ub_wr_en never asserted.
//   src=0x3FE, dst=0x3FF, rows=3 -> read addresses 0x3FE,0x3FF,0x000; writes 0x3FF,0x000,0x001.
//   rst asserted 2 cycles into a rows=8 job -> all outputs 0 asynchronously, no done;
//     a new rows=2 job after release completes normally.
//   start pulsed during RUN with different cfg -> ignored; the job finishes with the original sel/rows.

Source files
------------

// File: rtl/act_sched_pkg.sv
// Shared types and default widths for the activation scheduler.
package act_sched_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int ROW_W_DEF  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic [1:0] act_sel_t;

endpackage

// File: rtl/act_sched_pipe.sv
// Read-data / Activations valid pipeline with UB backpressure and write counter.
module act_sched_pipe #(
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,         // start of a new job: zero the write counter
    input  logic             issue,       // a read is issued this cycle
    input  logic             ub_wr_ready,
    output logic             stall,
    output logic             act_en,
    output logic             ub_wr_en,
    output logic             wr_accept,
    output logic [ROW_W-1:0] wr_cnt
);

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    logic [ROW_W-1:0] wr_cnt_q, wr_cnt_d;

    // A pending write that the UB refuses freezes the whole pipe.
    assign stall     = v2_q & ~ub_wr_ready;
    assign act_en    = v1_q & ~stall;
    assign ub_wr_en  = v2_q;
    assign wr_accept = v2_q & ub_wr_ready;
    assign wr_cnt    = wr_cnt_q;

    // Next-state: shift valids unless stalled; count accepted writes.
    always_comb begin
        v1_d     = v1_q;
        v2_d     = v2_q;
        wr_cnt_d = wr_cnt_q;
        if (!stall) begin
            v1_d = issue;
            v2_d = v1_q;
        end
        if (clr) begin
            wr_cnt_d = '0;
        end else if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + ROW_W'(1);
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            wr_cnt_q <= '0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

endmodule

// File: rtl/activation_scheduler.sv
// Sequences one activation job: accumulator reads -> Activations -> UB writes.
module activation_scheduler
    import act_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ROW_W  = ROW_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        cfg_sel,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [ADDR_W-1:0] cfg_src_base,
    input  logic [ADDR_W-1:0] cfg_dst_base,
    output logic              busy,
    output logic              done,
    output logic              acc_rd_en,
    output logic [ADDR_W-1:0] acc_rd_addr,
    output logic              act_en,
    output logic [1:0]        act_sel,
    output logic              ub_wr_en,
    output logic [ADDR_W-1:0] ub_wr_addr,
    input  logic              ub_wr_ready
);

    state_e            state_q, state_d;
    act_sel_t          sel_q, sel_d;
    logic [ROW_W-1:0]  rows_q, rows_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ROW_W-1:0]  rd_cnt_q, rd_cnt_d;

    logic              clr;
    logic              issue;
    logic              stall;
    logic              wr_accept;
    logic [ROW_W-1:0]  wr_cnt;
    logic              last_rd;
    logic              last_wr;

    assign issue   = (state_q == RUN) & ~stall;
    // rows_q is nonzero whenever RUN/DRAIN is reachable, so rows-1 never underflows there.
    assign last_rd = (rd_cnt_q == rows_q - ROW_W'(1));
    assign last_wr = wr_accept & (wr_cnt == rows_q - ROW_W'(1));

    assign busy        = (state_q == RUN) | (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign acc_rd_en   = issue;
    assign acc_rd_addr = src_q + ADDR_W'(rd_cnt_q);
    assign act_sel     = sel_q;

    act_sched_pipe #(.ROW_W(ROW_W)) u_pipe (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .issue       (issue),
        .ub_wr_ready (ub_wr_ready),
        .stall       (stall),
        .act_en      (act_en),
        .ub_wr_en    (ub_wr_en),
        .wr_accept   (wr_accept),
        .wr_cnt      (wr_cnt)
    );

    assign ub_wr_addr = dst_q + ADDR_W'(wr_cnt);

    // FSM next-state, config latch on accepted start, read counter.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rows_d   = rows_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rd_cnt_d = rd_cnt_q;
        clr      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d    = cfg_sel;
                    rows_d   = cfg_rows;
                    src_d    = cfg_src_base;
                    dst_d    = cfg_dst_base;
                    rd_cnt_d = '0;
                    clr      = 1'b1;
                    state_d  = (cfg_rows != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue) begin
                    rd_cnt_d = rd_cnt_q + ROW_W'(1);
                    if (last_rd) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_wr) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, config and read-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rows_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rows_q   <= rows_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

endmodule

// File: tb/tb_activation_scheduler.sv
// Randomized self-checking bench for activation_scheduler.
module tb_activation_scheduler;

    logic       clk, rst, start;
    logic [1:0] cfg_sel;
    logic [9:0] cfg_rows, cfg_src_base, cfg_dst_base;
    logic       busy, done, acc_rd_en, act_en, ub_wr_en, ub_wr_ready;
    logic [9:0] acc_rd_addr, ub_wr_addr;
    logic [1:0] act_sel;

    int n_chk  = 0;
    int n_fail = 0;

    // observations collected by run_job
    logic [9:0] rd_addrs[$];
    logic [9:0] wr_addrs[$];
    int         rd_cyc[$];
    int         wr_cyc[$];
    int         act_cnt, done_cnt, done_cyc, busy_cnt, hold_err, stall_err, sel_err;

    activation_scheduler #(.ADDR_W(10), .ROW_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_sel(cfg_sel), .cfg_rows(cfg_rows),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .busy(busy), .done(done),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .act_en(act_en), .act_sel(act_sel),
        .ub_wr_en(ub_wr_en), .ub_wr_addr(ub_wr_addr), .ub_wr_ready(ub_wr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one job and records what the DUT did; cycle 1 is the first cycle after start is taken.
    // mode 0: ready=1, mode 1: random ready, mode 2: ready=0 for 3 cycles at the first write.
    // inj_cyc>0 pulses start with a different config in that cycle.
    task automatic run_job(input logic [1:0] sel, input logic [9:0] rows, input logic [9:0] src,
                           input logic [9:0] dst, input int mode, input int inj_cyc);
        int  limit = int'(rows) * 8 + 20;
        bit  seen = 0;
        int  rem = 3;
        bit  prev_stall = 0;
        logic [9:0] prev_addr = '0;
        rd_addrs.delete(); wr_addrs.delete(); rd_cyc.delete(); wr_cyc.delete();
        act_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        hold_err = 0; stall_err = 0; sel_err = 0;
        @(posedge clk); #1;
        start = 1; cfg_sel = sel; cfg_rows = rows; cfg_src_base = src; cfg_dst_base = dst;
        ub_wr_ready = 1;
        @(posedge clk); #1;
        start = 0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            case (mode)
                1: ub_wr_ready = ($urandom_range(0, 99) < 60);
                2: begin
                    if (ub_wr_en) seen = 1;
                    if (seen && rem > 0) begin ub_wr_ready = 0; rem--; end
                    else ub_wr_ready = 1;
                end
                default: ub_wr_ready = 1;
            endcase
            if (cyc == inj_cyc) begin
                start = 1; cfg_sel = ~sel; cfg_rows = rows + 10'd5;
                cfg_src_base = src + 10'd7; cfg_dst_base = dst + 10'd9;
            end else begin
                start = 0;
            end
            @(negedge clk);
            if (acc_rd_en) begin rd_addrs.push_back(acc_rd_addr); rd_cyc.push_back(cyc); end
            if (act_en) act_cnt++;
            if (ub_wr_en && ub_wr_ready) begin wr_addrs.push_back(ub_wr_addr); wr_cyc.push_back(cyc); end
            if (busy) busy_cnt++;
            if (busy && act_sel !== sel) sel_err++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (ub_wr_en && !ub_wr_ready && (acc_rd_en || act_en)) stall_err++;
            if (prev_stall && !(ub_wr_en && ub_wr_addr == prev_addr)) hold_err++;
            prev_stall = ub_wr_en && !ub_wr_ready;
            prev_addr  = ub_wr_addr;
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            @(posedge clk); #1;
        end
        start = 0;
        ub_wr_ready = 1;
    endtask

    task automatic test_reset;
        #1;
        n_chk++;
        if ({busy, done, acc_rd_en, act_en, ub_wr_en} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b need 00000", {busy, done, acc_rd_en, act_en, ub_wr_en});
        end
        n_chk++;
        if (acc_rd_addr !== 10'h0 || ub_wr_addr !== 10'h0 || act_sel !== 2'b0) begin
            n_fail++; $display("FAIL reset_data: rd=%h wr=%h sel=%b need 0", acc_rd_addr, ub_wr_addr, act_sel);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_basic;
        int bad = 0;
        run_job(2'b01, 10'd4, 10'h010, 10'h200, 0, 0);
        for (int i = 0; i < rd_addrs.size(); i++)
            if (rd_addrs[i] !== 10'(16'h010 + i) || rd_cyc[i] != i + 1) bad++;
        n_chk++;
        if (rd_addrs.size() != 4 || bad != 0) begin
            n_fail++; $display("FAIL basic_reads: got %0d reads (%0d wrong) need 4 at 0x010.. cycles 1-4", rd_addrs.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < wr_addrs.size(); i++)
            if (wr_addrs[i] !== 10'(16'h200 + i) || wr_cyc[i] != i + 3) bad++;
        n_chk++;
        if (wr_addrs.size() != 4 || bad != 0) begin
            n_fail++; $display("FAIL basic_writes: got %0d writes (%0d wrong) need 4 at 0x200.. cycles 3-6", wr_addrs.size(), bad);
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != 7) begin
            n_fail++; $display("FAIL basic_done: got count %0d cycle %0d need 1 at 7", done_cnt, done_cyc);
        end
        n_chk++;
        if (sel_err != 0 || act_cnt != 4 || busy_cnt != 6) begin
            n_fail++; $display("FAIL basic_misc: sel_err %0d act %0d busy %0d need 0 4 6", sel_err, act_cnt, busy_cnt);
        end
    endtask

    task automatic test_backpressure;
        int bad = 0;
        run_job(2'b01, 10'd4, 10'h010, 10'h200, 2, 0);
        for (int i = 0; i < wr_addrs.size(); i++) if (wr_addrs[i] !== 10'(16'h200 + i)) bad++;
        n_chk++;
        if (wr_addrs.size() != 4 || bad != 0 || wr_cyc.size() < 1 || wr_cyc[0] != 6) begin
            n_fail++; $display("FAIL bp_writes: got %0d writes (%0d wrong) need 4 in order, first accepted cycle 6", wr_addrs.size(), bad);
        end
        n_chk++;
        if (hold_err != 0 || stall_err != 0) begin
            n_fail++; $display("FAIL bp_hold: hold_err %0d stall_err %0d need 0 0", hold_err, stall_err);
        end
        n_chk++;
        if (rd_addrs.size() != 4 || act_cnt != 4 || done_cnt != 1 || done_cyc != 4 + 3 + 3) begin
            n_fail++; $display("FAIL bp_done: reads %0d act %0d done %0d@%0d need 4 4 1@10", rd_addrs.size(), act_cnt, done_cnt, done_cyc);
        end
    endtask

    task automatic test_zero_rows;
        run_job(2'b10, 10'd0, 10'h055, 10'h0AA, 0, 0);
        n_chk++;
        if (rd_addrs.size() != 0 || act_cnt != 0 || wr_addrs.size() != 0 || busy_cnt != 0) begin
            n_fail++; $display("FAIL zero_activity: reads %0d act %0d writes %0d busy %0d need all 0", rd_addrs.size(), act_cnt, wr_addrs.size(), busy_cnt);
        end
        n_chk++;
        if (done_cnt != 1 || done_cyc != 1) begin
            n_fail++; $display("FAIL zero_done: got count %0d cycle %0d need 1 at 1", done_cnt, done_cyc);
        end
    endtask

    task automatic test_wrap;
        logic [9:0] er[3] = '{10'h3FE, 10'h3FF, 10'h000};
        logic [9:0] ew[3] = '{10'h3FF, 10'h000, 10'h001};
        int bad = 0;
        run_job(2'b11, 10'd3, 10'h3FE, 10'h3FF, 0, 0);
        for (int i = 0; i < 3 && i < rd_addrs.size(); i++) if (rd_addrs[i] !== er[i]) bad++;
        n_chk++;
        if (rd_addrs.size() != 3 || bad != 0) begin
            n_fail++; $display("FAIL wrap_reads: got %0d reads (%0d wrong) need 3FE 3FF 000", rd_addrs.size(), bad);
        end
        bad = 0;
        for (int i = 0; i < 3 && i < wr_addrs.size(); i++) if (wr_addrs[i] !== ew[i]) bad++;
        n_chk++;
        if (wr_addrs.size() != 3 || bad != 0 || done_cyc != 6) begin
            n_fail++; $display("FAIL wrap_writes: got %0d writes (%0d wrong) done %0d need 3FF 000 001 done 6", wr_addrs.size(), bad, done_cyc);
        end
    endtask

    task automatic test_reset_mid_job;
        int bad = 0;
        @(posedge clk); #1;
        start = 1; cfg_sel = 2'b11; cfg_rows = 10'd8; cfg_src_base = 10'h040; cfg_dst_base = 10'h080;
        ub_wr_ready = 1;
        @(posedge clk); #1; start = 0;
        @(posedge clk);
        @(posedge clk); #1;
        n_chk++;
        if (!(busy && acc_rd_en && ub_wr_en)) begin
            n_fail++; $display("FAIL rstmid_running: busy %b rd %b wr %b need 1 1 1", busy, acc_rd_en, ub_wr_en);
        end
        #1 rst = 1;
        #1;
        n_chk++;
        if ({busy, done, acc_rd_en, act_en, ub_wr_en} !== 5'b0 || acc_rd_addr !== 10'h0 ||
            ub_wr_addr !== 10'h0 || act_sel !== 2'b0) begin
            n_fail++; $display("FAIL rstmid_async: ctrl %b rd %h wr %h sel %b need all 0",
                               {busy, done, acc_rd_en, act_en, ub_wr_en}, acc_rd_addr, ub_wr_addr, act_sel);
        end
        repeat (2) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        rst = 0;
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rstmid_nodone: %0d cycles with done/busy in reset need 0", bad);
        end
        run_job(2'b10, 10'd2, 10'h123, 10'h321, 0, 0);
        n_chk++;
        if (rd_addrs.size() != 2 || wr_addrs.size() != 2 || wr_addrs[0] !== 10'h321 ||
            wr_addrs[1] !== 10'h322 || done_cyc != 5 || done_cnt != 1) begin
            n_fail++; $display("FAIL rstmid_after: reads %0d writes %0d done %0d@%0d need 2 2 1@5",
                               rd_addrs.size(), wr_addrs.size(), done_cnt, done_cyc);
        end
    endtask

    task automatic test_start_ignored;
        int bad = 0;
        run_job(2'b01, 10'd5, 10'h100, 10'h180, 0, 2);
        for (int i = 0; i < wr_addrs.size(); i++) if (wr_addrs[i] !== 10'(16'h180 + i)) bad++;
        n_chk++;
        if (wr_addrs.size() != 5 || bad != 0 || sel_err != 0 || done_cyc != 8 || busy_cnt != 7) begin
            n_fail++; $display("FAIL run_start: writes %0d (%0d wrong) sel_err %0d done %0d busy %0d need 5 0 0 8 7",
                               wr_addrs.size(), bad, sel_err, done_cyc, busy_cnt);
        end
        // start raised in the DONE cycle (cycle rows+3) must not launch a job
        run_job(2'b10, 10'd3, 10'h000, 10'h010, 0, 6);
        n_chk++;
        if (done_cnt != 1 || done_cyc != 6 || busy_cnt != 5 || rd_addrs.size() != 3) begin
            n_fail++; $display("FAIL done_start: done %0d@%0d busy %0d reads %0d need 1@6 5 3",
                               done_cnt, done_cyc, busy_cnt, rd_addrs.size());
        end
    endtask

    task automatic test_random;
        for (int j = 0; j < 6; j++) begin
            logic [1:0] sel  = 2'($urandom_range(0, 3));
            logic [9:0] rows = 10'($urandom_range(1, 24));
            logic [9:0] src  = 10'($urandom);
            logic [9:0] dst  = 10'($urandom);
            int bad = 0;
            run_job(sel, rows, src, dst, 1, 0);
            for (int i = 0; i < rd_addrs.size(); i++) if (rd_addrs[i] !== 10'((int'(src) + i) % 1024)) bad++;
            for (int i = 0; i < wr_addrs.size(); i++) if (wr_addrs[i] !== 10'((int'(dst) + i) % 1024)) bad++;
            n_chk++;
            if (rd_addrs.size() != int'(rows) || wr_addrs.size() != int'(rows) || bad != 0) begin
                n_fail++; $display("FAIL rand_seq[%0d]: reads %0d writes %0d wrong %0d need %0d each",
                                   j, rd_addrs.size(), wr_addrs.size(), bad, rows);
            end
            n_chk++;
            if (hold_err != 0 || stall_err != 0 || sel_err != 0 || act_cnt != int'(rows) || done_cnt != 1 ||
                wr_cyc.size() == 0 || done_cyc != wr_cyc[wr_cyc.size()-1] + 1 || busy_cnt != done_cyc - 1) begin
                n_fail++; $display("FAIL rand_proto[%0d]: hold %0d stall %0d sel %0d act %0d done %0d@%0d busy %0d",
                                   j, hold_err, stall_err, sel_err, act_cnt, done_cnt, done_cyc, busy_cnt);
            end
        end
    endtask

    initial begin
        rst = 1; start = 0; cfg_sel = 0; cfg_rows = 0; cfg_src_base = 0; cfg_dst_base = 0; ub_wr_ready = 1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_rows();
        test_wrap();
        test_reset_mid_job();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
